// File: rtl/iir_pkg.sv
// Shared types and width helpers for the IIR tap-memory datapath.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT_Y = 2'd2
    } state_e;

    localparam int DEFAULT_DATA_W = 32;

    // Width of a coefficient index covering taps 0..2*order.
    function automatic int tap_w(input int order);
        return $clog2(2 * order + 1);
    endfunction

    // Channel-select width; a single channel still gets a 1-bit port.
    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/iir_hist_bank.sv
// Per-channel x/y history registers. Slot 0 of each history is the newest
// sample (x[n-1] / y[n-1]); reads are combinational over a flat slot number.
module iir_hist_bank
    import iir_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ORDER  = 2,
    parameter int N_CH   = 4,
    parameter int CH_W   = ch_w(N_CH),
    parameter int SLOT_W = tap_w(ORDER)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              shx_en,
    input  logic [CH_W-1:0]   shx_ch,
    input  logic [DATA_W-1:0] shx_data,
    input  logic              shy_en,
    input  logic [CH_W-1:0]   shy_ch,
    input  logic [DATA_W-1:0] shy_data,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic [DATA_W-1:0] rd_data
);

    typedef logic [N_CH-1:0][ORDER-1:0][DATA_W-1:0] hist_t;

    hist_t x_hist_q, x_hist_d;
    hist_t y_hist_q, y_hist_d;

    // Slots 0..ORDER-1 are the x history, ORDER..2*ORDER-1 the y history.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        rd_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            for (int s = 0; s < ORDER; s++) begin
                if (32'(rd_ch) == c && 32'(rd_slot) == s)
                    rd_data = x_hist_q[c][s];
                if (32'(rd_ch) == c && 32'(rd_slot) == s + ORDER)
                    rd_data = y_hist_q[c][s];
            end
        end
    end

    always_comb begin
        x_hist_d = x_hist_q;
        y_hist_d = y_hist_q;
        for (int c = 0; c < N_CH; c++) begin
            if (shx_en && 32'(shx_ch) == c) begin
                for (int s = ORDER - 1; s > 0; s--)
                    x_hist_d[c][s] = x_hist_q[c][s-1];
                x_hist_d[c][0] = shx_data;
            end
            if (shy_en && 32'(shy_ch) == c) begin
                for (int s = ORDER - 1; s > 0; s--)
                    y_hist_d[c][s] = y_hist_q[c][s-1];
                y_hist_d[c][0] = shy_data;
            end
        end
        // NOTE: the history array is cleared on reset, unlike a plain data RAM, because stale samples would otherwise feed the first filter outputs.
        if (clear) begin
            x_hist_d = '0;
            y_hist_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        x_hist_q <= x_hist_d;
        y_hist_q <= y_hist_d;
    end

endmodule

// File: rtl/iir_tap_mem.sv
// Multi-channel DF-I history memory: accepts x[n], streams the 2*ORDER+1 taps
// to the MAC in coefficient order, then writes the returned y[n] back.
module iir_tap_mem
    import iir_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ORDER  = 2,
    parameter int N_CH   = 4,
    parameter int CH_W   = ch_w(N_CH),
    parameter int TAP_W  = tap_w(ORDER)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x_valid,
    input  logic [CH_W-1:0]   x_ch,
    input  logic [DATA_W-1:0] x_in,
    output logic              x_ready,
    output logic              tap_valid,
    input  logic              tap_ready,
    output logic [TAP_W-1:0]  tap_idx,
    output logic [CH_W-1:0]   tap_ch,
    output logic [DATA_W-1:0] tap_data,
    output logic              tap_last,
    input  logic              y_valid,
    input  logic [DATA_W-1:0] y_in,
    output logic              err_ch
);

    state_e              state_q, state_d;
    logic                tap_valid_q, tap_valid_d;
    logic [TAP_W-1:0]    tap_idx_q, tap_idx_d;
    logic [CH_W-1:0]     tap_ch_q, tap_ch_d;
    logic [DATA_W-1:0]   tap_data_q, tap_data_d;
    logic                tap_last_q, tap_last_d;
    logic [DATA_W-1:0]   x_lat_q, x_lat_d;
    logic                err_ch_q, err_ch_d;
    logic                shx_en, shy_en;
    logic [DATA_W-1:0]   rd_data;

    // The next tap (idx k+1) lives in history slot k, so the current index addresses the read.
    iir_hist_bank #(
        .DATA_W (DATA_W),
        .ORDER  (ORDER),
        .N_CH   (N_CH),
        .CH_W   (CH_W),
        .SLOT_W (TAP_W)
    ) u_hist (
        .clk      (clk),
        .clear    (reset),
        .shx_en   (shx_en),
        .shx_ch   (tap_ch_q),
        .shx_data (x_lat_q),
        .shy_en   (shy_en),
        .shy_ch   (tap_ch_q),
        .shy_data (y_in),
        .rd_ch    (tap_ch_q),
        .rd_slot  (tap_idx_q),
        .rd_data  (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        tap_valid_d = tap_valid_q;
        tap_idx_d   = tap_idx_q;
        tap_ch_d    = tap_ch_q;
        tap_data_d  = tap_data_q;
        tap_last_d  = tap_last_q;
        x_lat_d     = x_lat_q;
        err_ch_d    = 1'b0;
        shx_en      = 1'b0;
        shy_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (x_valid) begin
                    if (32'(x_ch) < N_CH) begin
                        x_lat_d     = x_in;
                        tap_ch_d    = x_ch;
                        tap_data_d  = x_in;
                        tap_idx_d   = '0;
                        tap_last_d  = 1'b0;
                        tap_valid_d = 1'b1;
                        state_d     = STREAM;
                    end else begin
                        err_ch_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (tap_ready) begin
                    if (tap_last_q) begin
                        shx_en      = 1'b1;
                        tap_valid_d = 1'b0;
                        tap_last_d  = 1'b0;
                        state_d     = WAIT_Y;
                    end else begin
                        tap_idx_d  = tap_idx_q + TAP_W'(1);
                        tap_data_d = rd_data;
                        tap_last_d = (32'(tap_idx_q) + 1 == 2 * ORDER);
                    end
                end
            end
            WAIT_Y: begin
                if (y_valid) begin
                    shy_en  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= IDLE;
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            tap_ch_q    <= '0;
            tap_data_q  <= '0;
            tap_last_q  <= 1'b0;
            x_lat_q     <= '0;
            err_ch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_valid_q <= tap_valid_d;
            tap_idx_q   <= tap_idx_d;
            tap_ch_q    <= tap_ch_d;
            tap_data_q  <= tap_data_d;
            tap_last_q  <= tap_last_d;
            x_lat_q     <= x_lat_d;
            err_ch_q    <= err_ch_d;
        end
    end

    assign x_ready   = (state_q == IDLE);
    assign tap_valid = tap_valid_q;
    assign tap_idx   = tap_idx_q;
    assign tap_ch    = tap_ch_q;
    assign tap_data  = tap_data_q;
    assign tap_last  = tap_last_q;
    assign err_ch    = err_ch_q;

endmodule

// File: tb/tb_iir_tap_mem.sv
// Scoreboard bench for iir_tap_mem: directed scenarios plus randomized traffic
// checked against a per-channel history model.
module tb_iir_tap_mem;

    localparam int DW    = 32;
    localparam int ORDER = 2;
    localparam int N_CH  = 4;
    localparam int NTAP  = 2 * ORDER + 1;
    // Channel ports are widened by one bit so out-of-range channel codes can be driven.
    localparam int CW    = 3;
    localparam int TW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          x_valid = 1'b0;
    logic [CW-1:0] x_ch = '0;
    logic [DW-1:0] x_in = '0;
    logic          x_ready;
    logic          tap_valid;
    logic          tap_ready = 1'b1;
    logic [TW-1:0] tap_idx;
    logic [CW-1:0] tap_ch;
    logic [DW-1:0] tap_data;
    logic          tap_last;
    logic          y_valid = 1'b0;
    logic [DW-1:0] y_in = '0;
    logic          err_ch;

    iir_tap_mem #(
        .DATA_W (DW),
        .ORDER  (ORDER),
        .N_CH   (N_CH),
        .CH_W   (CW),
        .TAP_W  (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x_valid   (x_valid),
        .x_ch      (x_ch),
        .x_in      (x_in),
        .x_ready   (x_ready),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_idx   (tap_idx),
        .tap_ch    (tap_ch),
        .tap_data  (tap_data),
        .tap_last  (tap_last),
        .y_valid   (y_valid),
        .y_in      (y_in),
        .err_ch    (err_ch)
    );

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [TW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } tap_t;

    tap_t          exp_q[$];
    logic [DW-1:0] xh[N_CH][ORDER];
    logic [DW-1:0] yh[N_CH][ORDER];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            stream_len = 0;
    bit            rdy_manual = 1'b1;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NTAP*DW-1:0] taps5(input int a0, a1, a2, a3, a4);
        return {DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    task automatic clear_model();
        for (int c = 0; c < N_CH; c++)
            for (int s = 0; s < ORDER; s++) begin
                xh[c][s] = '0;
                yh[c][s] = '0;
            end
        exp_q.delete();
    endtask

    // Tap-ready driver for the randomized phase; directed tests drive it by hand.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rdy_manual) tap_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on every tap handshake and checks stall stability.
    initial begin : monitor
        tap_t          e;
        bit            stall = 1'b0;
        bit            prev_valid = 1'b0;
        int            start_cyc = 0;
        logic [TW-1:0] p_idx;
        logic [CW-1:0] p_ch;
        logic [DW-1:0] p_data;
        logic          p_last;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
                prev_valid = 1'b0;
                continue;
            end
            if (stall) begin
                check("stall_valid", tap_valid, 1'b1);
                check("stall_idx", tap_idx, p_idx);
                check("stall_ch", tap_ch, p_ch);
                check("stall_data", tap_data, p_data);
                check("stall_last", tap_last, p_last);
            end
            if (tap_valid && !prev_valid) start_cyc = cyc;
            if (tap_valid && tap_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tap: got idx %0d data 0x%0h, required none (cycle %0d)",
                             tap_idx, tap_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("tap_ch", tap_ch, e.ch);
                    check("tap_idx", tap_idx, e.idx);
                    check("tap_data", tap_data, e.data);
                    check("tap_last", tap_last, e.last);
                end
                if (tap_last) stream_len = cyc - start_cyc + 1;
            end
            stall = tap_valid && !tap_ready;
            prev_valid = tap_valid;
            p_idx = tap_idx;
            p_ch = tap_ch;
            p_data = tap_data;
            p_last = tap_last;
        end
    end

    task automatic reset_dut();
        reset = 1'b1;
        x_valid = 1'b0;
        y_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clear_model();
        reset = 1'b0;
    endtask

    // Offers x on channel ch; for a valid channel the expected taps are queued
    // (from lit if use_lit, else from the model) and the model's x history shifts.
    task automatic send_x(input logic [CW-1:0] ch, input logic [DW-1:0] x,
                          input bit use_lit, input logic [NTAP*DW-1:0] lit);
        tap_t e;
        int   n = 0;
        bit   ok = (32'(ch) < N_CH);
        while (!x_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!x_ready) begin
            check("x_ready_timeout", x_ready, 1'b1);
            return;
        end
        if (ok) begin
            for (int k = 0; k < NTAP; k++) begin
                e.ch = ch;
                e.idx = TW'(k);
                e.last = (k == NTAP - 1);
                if (use_lit)          e.data = lit[k*DW +: DW];
                else if (k == 0)      e.data = x;
                else if (k <= ORDER)  e.data = xh[ch][k-1];
                else                  e.data = yh[ch][k-1-ORDER];
                exp_q.push_back(e);
            end
            for (int s = ORDER - 1; s > 0; s--) xh[ch][s] = xh[ch][s-1];
            xh[ch][0] = x;
        end
        x_valid = 1'b1;
        x_ch = ch;
        x_in = x;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        x_ch = CW'($urandom);
        x_in = $urandom;
        if (ok) begin
            check("accept_tap_valid", tap_valid, 1'b1);
            check("accept_tap_idx", tap_idx, '0);
            check("accept_x_ready", x_ready, 1'b0);
        end else begin
            check("err_ch_pulse", err_ch, 1'b1);
            check("err_tap_valid", tap_valid, 1'b0);
            check("err_x_ready", x_ready, 1'b1);
            @(posedge clk);
            #1;
            check("err_ch_clear", err_ch, 1'b0);
        end
    endtask

    // Waits for WAIT_Y, returns y for channel ch and updates the model's y history.
    task automatic send_y(input logic [CW-1:0] ch, input logic [DW-1:0] y, input int delay);
        int n = 0;
        while (!(tap_valid === 1'b0 && x_ready === 1'b0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            check("wait_y_timeout", n, 0);
            return;
        end
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        check("wait_y_x_ready", x_ready, 1'b0);
        y_valid = 1'b1;
        y_in = y;
        @(posedge clk);
        #1;
        y_valid = 1'b0;
        y_in = $urandom;
        for (int s = ORDER - 1; s > 0; s--) yh[ch][s] = yh[ch][s-1];
        yh[ch][0] = y;
        check("x_ready_after_y", x_ready, 1'b1);
    endtask

    initial begin
        clear_model();
        reset_dut();

        check("rst_tap_valid", tap_valid, 1'b0);
        check("rst_tap_idx", tap_idx, '0);
        check("rst_tap_ch", tap_ch, '0);
        check("rst_tap_data", tap_data, '0);
        check("rst_tap_last", tap_last, 1'b0);
        check("rst_err_ch", err_ch, 1'b0);
        check("rst_x_ready", x_ready, 1'b1);

        // Fresh channel 0 stream, then history accumulation on channel 0.
        tap_ready = 1'b1;
        send_x(0, 5, 1, taps5(5, 0, 0, 0, 0));
        send_y(0, 7, 0);
        check("t1_stream_len", stream_len, 5);
        send_x(0, 6, 1, taps5(6, 5, 0, 7, 0));
        send_y(0, 8, 1);
        send_x(0, 9, 1, taps5(9, 6, 5, 8, 7));
        send_y(0, 3, 0);

        // Channel isolation.
        reset_dut();
        send_x(0, 1, 1, taps5(1, 0, 0, 0, 0));
        send_y(0, 2, 0);
        send_x(1, 100, 1, taps5(100, 0, 0, 0, 0));
        send_y(1, 200, 2);
        send_x(0, 3, 1, taps5(3, 1, 0, 2, 0));
        send_y(0, 4, 0);

        // Three-cycle bubble while idx 2 is presented.
        send_x(0, 10, 1, taps5(10, 3, 1, 4, 2));
        @(posedge clk); #1;
        @(posedge clk); #1;
        tap_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bubble_idx", tap_idx, 2);
            check("bubble_data", tap_data, 1);
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        tap_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bubble_next_idx", tap_idx, 3);
        send_y(0, 11, 0);
        check("t4_stream_len", stream_len, 8);

        // Out-of-range channel, then y_valid while idle must not touch history.
        send_x(4, 32'hdead_beef, 0, '0);
        y_valid = 1'b1;
        y_in = 55;
        @(posedge clk);
        #1;
        y_valid = 1'b0;
        check("idle_y_x_ready", x_ready, 1'b1);
        send_x(1, 7, 1, taps5(7, 100, 0, 200, 0));
        send_y(1, 9, 0);

        // Reset in the middle of a stream.
        send_x(1, 8, 1, taps5(8, 7, 100, 9, 200));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_idx", tap_idx, 3);
        reset = 1'b1;
        tap_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        check("mid_rst_tap_valid", tap_valid, 1'b0);
        check("mid_rst_x_ready", x_ready, 1'b1);
        check("mid_rst_tap_data", tap_data, '0);
        tap_ready = 1'b1;
        send_x(1, 4, 1, taps5(4, 0, 0, 0, 0));
        send_y(1, 1, 0);

        // Randomized traffic against the history model.
        rdy_manual = 1'b0;
        for (int t = 0; t < 80; t++) begin
            logic [CW-1:0] ch;
            ch = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(N_CH, 7)) : CW'($urandom_range(0, N_CH - 1));
            if ($urandom_range(0, 5) == 0) begin
                y_valid = 1'b1;
                y_in = $urandom;
                @(posedge clk);
                #1;
                y_valid = 1'b0;
            end
            send_x(ch, $urandom, 0, '0);
            if (32'(ch) < N_CH) send_y(ch, $urandom, $urandom_range(0, 3));
        end
        rdy_manual = 1'b1;
        tap_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
